// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA AHB-Lite master.
// Bus encodings plus the engine state enum.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_RD_DRAIN,
    S_WR,
    S_WR_DRAIN,
    S_DONE
  } dma_state_t;

  localparam logic [2:0] HSIZE_WORD = 3'b010;
  localparam logic [1:0] HRESP_OKAY = 2'b00;

endpackage

// File: rtl/dma_ahb_master_if.sv
// Command handshake and AHB-Lite bus bundle of the DMA engine.
// master = DMA side, slave = command source plus bus slave side.
interface dma_ahb_master_if #(
  parameter int LEN_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [31:0]      cmd_src;
  logic [31:0]      cmd_dst;
  logic [LEN_W-1:0] cmd_len;
  logic [31:0]      HADDR;
  logic [1:0]       HTRANS;
  logic             HWRITE;
  logic [2:0]       HSIZE;
  logic [31:0]      HWDATA;
  logic [3:0]       WSTRB;
  logic [31:0]      HRDATA;
  logic             HREADY;
  logic [1:0]       HRESP;

  modport master (
    input  cmd_valid, cmd_src, cmd_dst, cmd_len,
    input  HRDATA, HREADY, HRESP,
    output cmd_ready,
    output HADDR, HTRANS, HWRITE, HSIZE,
    output HWDATA, WSTRB
  );

  modport slave (
    output cmd_valid, cmd_src, cmd_dst, cmd_len,
    output HRDATA, HREADY, HRESP,
    input  cmd_ready,
    input  HADDR, HTRANS, HWRITE, HSIZE,
    input  HWDATA, WSTRB
  );
endinterface

// File: rtl/dma_sync_fifo.sv
// Synchronous word FIFO buffering one DMA chunk.
// Power-of-two depth; flush empties it in one cycle.
module dma_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  count
);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;

  assign rdata = mem[rp];
  assign full  = count == (AW+1)'(DEPTH);
  assign empty = count == '0;

  always_ff @(posedge clk) begin
    if (push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/dma_ahb_master.sv
// Single-channel DMA copy engine, AHB-Lite master, chunked by FIFO depth.
// Optional DMA_IRQ_EN adds a sticky irq output with irq_clr input.
module dma_ahb_master
  import dma_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16
) (
  input  logic HCLK,
  input  logic HRESET,
  dma_ahb_master_if.master bus,
  output logic busy,
  output logic done,
  output logic err
`ifdef DMA_IRQ_EN
  ,
  output logic irq,
  input  logic irq_clr
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dma_state_t       state;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] beats;
  logic [31:0]      src_a;
  logic [31:0]      dst_a;
  logic             dph_vld;
  logic             dph_wr;

  logic [31:0]      head;
  logic [CW-1:0]    fcnt;
  logic             full;
  logic             empty;

  logic             okay;
  logic             dph_done;
  logic             dph_err;
  logic             push;
  logic             pop;
  logic             idle_st;
  logic [LEN_W-1:0] rem_in;
  logic [31:0]      src_in;
  logic [LEN_W-1:0] rd_n;
  logic [LEN_W-1:0] wr_n;

  assign okay     = bus.HRESP == HRESP_OKAY;
  assign dph_done = dph_vld && bus.HREADY && okay;
  assign dph_err  = dph_vld && bus.HREADY && !okay;
  assign push     = dph_done && !dph_wr && !full;
  assign pop      = dph_done && dph_wr && !empty;

  // Next read chunk comes from the command in IDLE, else from leftovers.
  assign idle_st = state == S_IDLE;
  assign rem_in  = idle_st ? bus.cmd_len : rem;
  assign src_in  = idle_st ? {bus.cmd_src[31:2], 2'b00} : src_a;
  assign rd_n    = (rem_in > LEN_W'(FIFO_DEPTH))
                 ? LEN_W'(FIFO_DEPTH) : rem_in;
  // Write out everything buffered, including the word landing this edge.
  assign wr_n    = LEN_W'(fcnt) + LEN_W'(1);

  assign bus.HSIZE  = HSIZE_WORD;
  assign bus.HWDATA = (dph_vld && dph_wr) ? head : '0;
  assign bus.WSTRB  = (dph_vld && dph_wr) ? 4'hF : 4'h0;

  dma_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (HCLK),
    .rst   (HRESET),
    .push  (push),
    .pop   (pop),
    .flush (dph_err),
    .wdata (bus.HRDATA),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fcnt)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state         <= S_IDLE;
      bus.cmd_ready <= 1'b1;
      bus.HADDR     <= '0;
      bus.HTRANS    <= IDLE;
      bus.HWRITE    <= 1'b0;
      rem           <= '0;
      beats         <= '0;
      src_a         <= '0;
      dst_a         <= '0;
      dph_vld       <= 1'b0;
      dph_wr        <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (bus.HREADY) begin
        dph_vld <= bus.HTRANS[1];
        dph_wr  <= bus.HWRITE;
      end
      if (dph_err) begin
        state      <= S_DONE;
        bus.HTRANS <= IDLE;
        bus.HWRITE <= 1'b0;
        dph_vld    <= 1'b0;
        rem        <= '0;
        busy       <= 1'b0;
        done       <= 1'b1;
        err        <= 1'b1;
      end else begin
        unique case (state)
          S_IDLE: begin
            if (bus.cmd_valid) begin
              bus.cmd_ready <= 1'b0;
              dst_a <= {bus.cmd_dst[31:2], 2'b00};
              if (bus.cmd_len == '0) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                busy       <= 1'b1;
                state      <= S_RD;
                bus.HADDR  <= src_in;
                bus.HTRANS <= NONSEQ;
                bus.HWRITE <= 1'b0;
                beats      <= rd_n;
                rem        <= rem_in - rd_n;
                src_a      <= src_in + (32'(rd_n) << 2);
              end
            end
          end
          S_RD, S_WR: begin
            if (bus.HREADY) begin
              beats <= beats - LEN_W'(1);
              if (beats == LEN_W'(1)) begin
                bus.HTRANS <= IDLE;
                state <= (state == S_RD)
                       ? S_RD_DRAIN : S_WR_DRAIN;
              end else begin
                bus.HADDR  <= bus.HADDR + 32'd4;
                bus.HTRANS <= SEQ;
              end
            end
          end
          S_RD_DRAIN: begin
            if (dph_done) begin
              state      <= S_WR;
              bus.HADDR  <= dst_a;
              bus.HTRANS <= NONSEQ;
              bus.HWRITE <= 1'b1;
              beats      <= wr_n;
              dst_a      <= dst_a + (32'(wr_n) << 2);
            end
          end
          S_WR_DRAIN: begin
            if (dph_done) begin
              if (rem != '0) begin
                state      <= S_RD;
                bus.HADDR  <= src_in;
                bus.HTRANS <= NONSEQ;
                bus.HWRITE <= 1'b0;
                beats      <= rd_n;
                rem        <= rem_in - rd_n;
                src_a      <= src_in + (32'(rd_n) << 2);
              end else begin
                state      <= S_DONE;
                bus.HWRITE <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b1;
              end
            end
          end
          S_DONE: begin
            state         <= S_IDLE;
            bus.cmd_ready <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef DMA_IRQ_EN
  // A new completion beats a simultaneous clear.
  always_ff @(posedge HCLK) begin
    if (HRESET) irq <= 1'b0;
    else        irq <= done || (irq && !irq_clr);
  end
`endif
endmodule

// File: tb/tb_dma_ahb_master.sv
// Self-checking bench for dma_ahb_master with a behavioural AHB slave.
// Expected bus order, data and completion cycle come from a copy model.
module tb_dma_ahb_master;
  localparam int D  = 8;
  localparam int LW = 16;

  typedef struct {
    logic [31:0] a;
    logic [1:0]  t;
    logic        w;
  } aph_t;

  logic HCLK = 1'b0;
  logic HRESET = 1'b1;
  logic busy, done, err;
`ifdef DMA_IRQ_EN
  logic irq;
  logic irq_clr = 1'b0;
`endif

  dma_ahb_master_if #(.LEN_W(LW)) bus ();

  dma_ahb_master #(
    .FIFO_DEPTH (D),
    .LEN_W      (LW)
  ) dut (
    .HCLK    (HCLK),
    .HRESET  (HRESET),
    .bus     (bus),
    .busy    (busy),
    .done    (done),
    .err     (err)
`ifdef DMA_IRQ_EN
    ,
    .irq     (irq),
    .irq_clr (irq_clr)
`endif
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int fails  = 0;
  bit [31:0] mem [bit [31:0]];
  aph_t exq [$];
  logic        dp_v, dp_w;
  logic [31:0] dp_a;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  task automatic run_cmd(input logic [31:0] src,
                         input logic [31:0] dst,
                         input int len, input int wpct,
                         input int st_at, input int st_n,
                         input int err_wb, input int rst_wb,
                         input bit noisy, output int dk);
    logic [31:0] srcw [$];
    logic [31:0] sa, da, p_addr, p_wd;
    logic [1:0]  p_tr;
    bit          hr, p_hr, p_wdp, cur_wdp;
    int base, waits, prog, wb, err_k, rem, c, nbad;
    aph_t e;
    dk = 0; waits = 0; prog = 0; wb = 0; err_k = -1;
    p_hr = 1'b1; p_wdp = 1'b0; p_tr = 2'b00;
    p_addr = '0; p_wd = '0;
    dp_v = 1'b0; dp_w = 1'b0; dp_a = '0;
    exq.delete();
    for (int i = 0; i < len; i++) begin
      logic [31:0] v;
      v = $urandom;
      mem[src + 32'(4 * i)] = v;
      mem[dst + 32'(4 * i)] = 32'hA5A5_0000 | 32'(i);
      srcw.push_back(v);
    end
    // Copy model: chunks of at most D words, each costing 2c+2 cycles.
    base = 0; rem = len; sa = src; da = dst;
    while (rem > 0) begin
      c = (rem > D) ? D : rem;
      for (int i = 0; i < c; i++)
        exq.push_back('{sa + 32'(4 * i),
                        (i == 0) ? 2'b10 : 2'b11, 1'b0});
      for (int i = 0; i < c; i++)
        exq.push_back('{da + 32'(4 * i),
                        (i == 0) ? 2'b10 : 2'b11, 1'b1});
      sa = sa + 32'(4 * c);
      da = da + 32'(4 * c);
      base += 2 * c + 2;
      rem -= c;
    end

    @(negedge HCLK);
    chk("rdy_idle", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_src   = src;
    bus.cmd_dst   = dst;
    bus.cmd_len   = LW'(len);
    bus.HREADY    = 1'b1;
    bus.HRESP     = 2'b00;
    for (int k = 1; k <= 1500; k++) begin
      @(negedge HCLK);
      if (k == 1) begin
        bus.cmd_valid = noisy;
        chk("rdy_low", bus.cmd_ready, 0);
        chk("busy_on", busy, (len != 0) ? 1 : 0);
      end
      if (noisy) bus.cmd_len = LW'($urandom_range(1, 5));
      if (k > 1 && !p_hr && p_tr[1]) begin
        chk("hold_addr", bus.HADDR, p_addr);
        chk("hold_trans", bus.HTRANS, p_tr);
      end
      if (k > 1 && !p_hr && p_wdp)
        chk("hold_wdata", bus.HWDATA, p_wd);
      if (done) begin
        dk = k;
        break;
      end
      hr = 1'b1;
      if (prog < base) begin
        if ((k >= st_at && k < st_at + st_n) ||
            $urandom_range(0, 99) < wpct) hr = 1'b0;
        if (hr) prog++;
        else waits++;
      end
      bus.HREADY = hr;
      bus.HRESP  = 2'b00;
      bus.HRDATA = (hr && dp_v && !dp_w) ? mrd(dp_a) : $urandom;
      cur_wdp = dp_v && dp_w;
      if (cur_wdp && hr) begin
        wb++;
        chk("wdata", bus.HWDATA, srcw[wb-1]);
        chk("wstrb", bus.WSTRB, 4'hF);
        if (wb == rst_wb) begin
          HRESET = 1'b1;
          @(negedge HCLK);
          chk("rst_trans", bus.HTRANS, 0);
          chk("rst_busy", busy, 0);
          chk("rst_rdy", bus.cmd_ready, 1);
          chk("rst_done", done, 0);
          HRESET = 1'b0;
          bus.cmd_valid = 1'b0;
          dk = -1;
          return;
        end
        if (wb == err_wb) begin
          bus.HRESP = 2'b01;
          err_k = k;
        end else begin
          mem[dp_a] = bus.HWDATA;
        end
      end
      if (hr && bus.HTRANS[1] && err_k != k) begin
        if (exq.size() == 0) begin
          chk("extra_aph", bus.HADDR, 32'hFFFF_FFFF);
        end else begin
          e = exq.pop_front();
          chk("aph_addr", bus.HADDR, e.a);
          chk("aph_trans", bus.HTRANS, e.t);
          chk("aph_wr", bus.HWRITE, e.w);
        end
      end
      p_hr   = hr;
      p_addr = bus.HADDR;
      p_tr   = bus.HTRANS;
      p_wdp  = cur_wdp;
      p_wd   = bus.HWDATA;
      if (hr) begin
        dp_v = bus.HTRANS[1] && (err_k != k);
        dp_a = bus.HADDR;
        dp_w = bus.HWRITE;
      end
    end
    bus.cmd_valid = 1'b0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 2'b00;
    chk("finished", (dk != 0) ? 1 : 0, 1);
    if (err_wb != 0) chk("done_cyc", dk, err_k + 1);
    else             chk("done_cyc", dk, base + waits + 1);
    chk("err_flag", err, (err_wb != 0) ? 1 : 0);
    chk("trans_done", bus.HTRANS, 0);
    @(negedge HCLK);
    chk("done_pulse", done, 0);
    chk("err_pulse", err, 0);
    chk("rdy_after", bus.cmd_ready, 1);
    chk("busy_after", busy, 0);
    if (err_wb == 0) begin
      nbad = 0;
      for (int i = 0; i < len; i++)
        if (mrd(dst + 32'(4 * i)) !== srcw[i]) nbad++;
      chk("dst_data", nbad, 0);
      chk("aph_left", exq.size(), 0);
    end else begin
      chk("err_nowrite", mrd(dst + 32'(4 * err_wb)),
          32'hA5A5_0000 | 32'(err_wb));
    end
  endtask

  int dk;
  logic [31:0] rs;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_src   = '0;
    bus.cmd_dst   = '0;
    bus.cmd_len   = '0;
    bus.HRDATA    = '0;
    bus.HREADY    = 1'b1;
    bus.HRESP     = 2'b00;
    repeat (2) @(negedge HCLK);
    chk("rst_rdy", bus.cmd_ready, 1);
    chk("rst_htrans", bus.HTRANS, 0);
    chk("rst_haddr", bus.HADDR, 0);
    chk("rst_hwrite", bus.HWRITE, 0);
    chk("rst_hsize", bus.HSIZE, 3'b010);
    chk("rst_wstrb", bus.WSTRB, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    HRESET = 1'b0;

    run_cmd(32'h0, 32'h100, 4, 0, 0, 0, 0, 0, 1'b0, dk);
    chk("t1_done_at", dk, 11);
`ifdef DMA_IRQ_EN
    chk("irq_set", irq, 1);
    irq_clr = 1'b1;
    @(negedge HCLK);
    irq_clr = 1'b0;
    chk("irq_clr", irq, 0);
`endif
    run_cmd(32'h0, 32'h400, 20, 0, 0, 0, 0, 0, 1'b1, dk);
    chk("t2_done_at", dk, 47);
    run_cmd(32'h800, 32'hC00, 4, 0, 2, 3, 0, 0, 1'b0, dk);
    chk("t3_done_at", dk, 14);
    run_cmd(32'h1000, 32'h1400, 6, 0, 0, 0, 3, 0, 1'b0, dk);
    chk("t4_done_at", dk, 12);
    run_cmd(32'h1800, 32'h1C00, 0, 0, 0, 0, 0, 0, 1'b0, dk);
    chk("t5_done_at", dk, 1);
    run_cmd(32'h2000, 32'h2400, 4, 0, 0, 0, 0, 2, 1'b0, dk);
    run_cmd(32'h2800, 32'h2C00, 2, 0, 0, 0, 0, 0, 1'b0, dk);
    chk("t6_done_at", dk, 7);
    run_cmd(32'hFFFF_FFF0, 32'h3000, 8, 20, 0, 0, 0, 0, 1'b0, dk);
    for (int n = 0; n < 8; n++) begin
      rs = ($urandom & 32'h00FF_FFFC) | 32'h1000_0000;
      run_cmd(rs, rs ^ 32'h0100_0000, $urandom_range(1, 20),
              25, 0, 0, 0, 0, n[0], dk);
    end
    run_cmd(32'h5000, 32'h5800, 13, 0, 0, 0, 11, 0, 1'b0, dk);
    run_cmd(32'h6000, 32'h6800, 9, 30, 0, 0, 0, 0, 1'b0, dk);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
